// File: rtl/bus_arb.sv
// bus_arb: two-port round-robin arbiter sharing one downstream bus slave.
// Ports: main_clk_i/main_rst_i, requester a_bus_*/b_bus_*, downstream bus_*, busy_o, timeout_o.
module bus_arb #(
   parameter int timeout_p = 15
) (
   input  logic        main_clk_i,
   input  logic        main_rst_i,
   input  logic [1:0]  a_bus_trans_i,
   input  logic [31:0] a_bus_addr_i,
   input  logic        a_bus_write_i,
   input  logic [31:0] a_bus_wdata_i,
   output logic        a_bus_ready_o,
   output logic        a_bus_resp_o,
   output logic [31:0] a_bus_rdata_o,
   input  logic [1:0]  b_bus_trans_i,
   input  logic [31:0] b_bus_addr_i,
   input  logic        b_bus_write_i,
   input  logic [31:0] b_bus_wdata_i,
   output logic        b_bus_ready_o,
   output logic        b_bus_resp_o,
   output logic [31:0] b_bus_rdata_o,
   output logic [1:0]  bus_trans_o,
   output logic [31:0] bus_addr_o,
   output logic        bus_write_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ready_i,
   input  logic        bus_resp_i,
   input  logic [31:0] bus_rdata_i,
   output logic        busy_o,
   output logic        timeout_o
);

   localparam int TW = (timeout_p < 1) ? 1 : $clog2(timeout_p + 1);
   localparam logic [TW-1:0] TMAX = TW'(timeout_p);
   localparam logic [TW-1:0] ONE = TW'(1);
   localparam bit TO_EN = (timeout_p != 0);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_A,
      BUSY_B
   } state_t;

   state_t          state_q, state_d;
   logic            prio_q, prio_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;

   logic a_req, b_req;
   logic sel_a, sel_b, busy, abort;
   logic        rsp_ready, rsp_resp;
   logic [31:0] rsp_rdata;

   assign a_req = |a_bus_trans_i;
   assign b_req = |b_bus_trans_i;
   assign sel_a = (state_q == BUSY_A);
   assign sel_b = (state_q == BUSY_B);
   assign busy  = sel_a | sel_b;

   // Slave completion in the last counted cycle beats the abort.
   assign abort = busy & ~bus_ready_i & TO_EN & (tcnt_q == TMAX);

   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         tcnt_q  <= tcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         IDLE: begin
            if (a_req && (!b_req || !prio_q)) begin
               state_d = BUSY_A;
               prio_d  = 1'b1;
               tcnt_d  = '0;
            end else if (b_req) begin
               state_d = BUSY_B;
               prio_d  = 1'b0;
               tcnt_d  = '0;
            end
         end
         BUSY_A, BUSY_B: begin
            if (bus_ready_i || abort) begin
               state_d = IDLE;
            end else if (TO_EN && (tcnt_q != TMAX)) begin
               tcnt_d = tcnt_q + ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus_trans_o = 2'b00;
      bus_addr_o  = '0;
      bus_write_o = 1'b0;
      bus_wdata_o = '0;
      if (sel_a) begin
         bus_trans_o = a_bus_trans_i;
         bus_addr_o  = a_bus_addr_i;
         bus_write_o = a_bus_write_i;
         bus_wdata_o = a_bus_wdata_i;
      end else if (sel_b) begin
         bus_trans_o = b_bus_trans_i;
         bus_addr_o  = b_bus_addr_i;
         bus_write_o = b_bus_write_i;
         bus_wdata_o = b_bus_wdata_i;
      end
      if (abort) begin
         bus_trans_o = 2'b00;
      end
   end

   // Abort looks like an error completion to the granted requester.
   assign rsp_ready = bus_ready_i | abort;
   assign rsp_resp  = abort ? 1'b1 : bus_resp_i;
   assign rsp_rdata = abort ? 32'h0 : bus_rdata_i;

   assign a_bus_ready_o = sel_a & rsp_ready;
   assign a_bus_resp_o  = sel_a & rsp_resp;
   assign a_bus_rdata_o = sel_a ? rsp_rdata : 32'h0;
   assign b_bus_ready_o = sel_b & rsp_ready;
   assign b_bus_resp_o  = sel_b & rsp_resp;
   assign b_bus_rdata_o = sel_b ? rsp_rdata : 32'h0;

   assign busy_o    = busy;
   assign timeout_o = abort;

endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: random stimulus against two arbiters (timeout 15 and 0),
// checked cycle by cycle against a transaction-level ownership model.
module tb_bus_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  a_trans, b_trans;
   logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
   logic        a_write, b_write;
   logic        s_ready, s_resp;
   logic [31:0] s_rdata;

   logic        a_ready [2];
   logic        a_resp  [2];
   logic [31:0] a_rdata [2];
   logic        b_ready [2];
   logic        b_resp  [2];
   logic [31:0] b_rdata [2];
   logic [1:0]  o_trans [2];
   logic [31:0] o_addr  [2];
   logic        o_write [2];
   logic [31:0] o_wdata [2];
   logic        o_busy  [2];
   logic        o_tmo   [2];

   bus_arb #(.timeout_p(15)) dut15 (
      .main_clk_i(clk), .main_rst_i(rst),
      .a_bus_trans_i(a_trans), .a_bus_addr_i(a_addr),
      .a_bus_write_i(a_write), .a_bus_wdata_i(a_wdata),
      .a_bus_ready_o(a_ready[0]), .a_bus_resp_o(a_resp[0]),
      .a_bus_rdata_o(a_rdata[0]),
      .b_bus_trans_i(b_trans), .b_bus_addr_i(b_addr),
      .b_bus_write_i(b_write), .b_bus_wdata_i(b_wdata),
      .b_bus_ready_o(b_ready[0]), .b_bus_resp_o(b_resp[0]),
      .b_bus_rdata_o(b_rdata[0]),
      .bus_trans_o(o_trans[0]), .bus_addr_o(o_addr[0]),
      .bus_write_o(o_write[0]), .bus_wdata_o(o_wdata[0]),
      .bus_ready_i(s_ready), .bus_resp_i(s_resp), .bus_rdata_i(s_rdata),
      .busy_o(o_busy[0]), .timeout_o(o_tmo[0])
   );

   bus_arb #(.timeout_p(0)) dut0 (
      .main_clk_i(clk), .main_rst_i(rst),
      .a_bus_trans_i(a_trans), .a_bus_addr_i(a_addr),
      .a_bus_write_i(a_write), .a_bus_wdata_i(a_wdata),
      .a_bus_ready_o(a_ready[1]), .a_bus_resp_o(a_resp[1]),
      .a_bus_rdata_o(a_rdata[1]),
      .b_bus_trans_i(b_trans), .b_bus_addr_i(b_addr),
      .b_bus_write_i(b_write), .b_bus_wdata_i(b_wdata),
      .b_bus_ready_o(b_ready[1]), .b_bus_resp_o(b_resp[1]),
      .b_bus_rdata_o(b_rdata[1]),
      .bus_trans_o(o_trans[1]), .bus_addr_o(o_addr[1]),
      .bus_write_o(o_write[1]), .bus_wdata_o(o_wdata[1]),
      .bus_ready_i(s_ready), .bus_resp_i(s_resp), .bus_rdata_i(s_rdata),
      .busy_o(o_busy[1]), .timeout_o(o_tmo[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: owner 0 = nobody, 1 = A, 2 = B; age = BUSY cycles so far.
   int tmo [2] = '{15, 0};
   int owner [2];
   int age [2];
   int prio [2];
   int aborts_seen = 0;
   int long_done = 0;
   int b_wins = 0;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         owner[k] = 0;
         age[k] = 0;
         prio[k] = 0;
      end
   endtask

   function automatic bit is_abort(input int k);
      return owner[k] != 0 && !s_ready && tmo[k] != 0 && age[k] == tmo[k] + 1;
   endfunction

   task automatic compare(input int k);
      logic        ab;
      logic [1:0]  et;
      logic [31:0] ead, ewd;
      logic        ewr;
      logic [33:0] ea, eb, rsp;
      ab = is_abort(k);
      et = 2'b00; ead = '0; ewd = '0; ewr = 1'b0;
      if (owner[k] == 1) begin
         et = a_trans; ead = a_addr; ewd = a_wdata; ewr = a_write;
      end else if (owner[k] == 2) begin
         et = b_trans; ead = b_addr; ewd = b_wdata; ewr = b_write;
      end
      if (ab) et = 2'b00;
      rsp = ab ? {1'b1, 1'b1, 32'h0} : {s_ready, s_resp, s_rdata};
      ea = (owner[k] == 1) ? rsp : '0;
      eb = (owner[k] == 2) ? rsp : '0;
      check($sformatf("trans%0d", k), 64'(o_trans[k]), 64'(et));
      check($sformatf("addr%0d", k), 64'(o_addr[k]), 64'(ead));
      check($sformatf("wr_wdata%0d", k), {31'h0, o_write[k], o_wdata[k]},
            {31'h0, ewr, ewd});
      check($sformatf("a_rsp%0d", k),
            64'({a_ready[k], a_resp[k], a_rdata[k]}), 64'(ea));
      check($sformatf("b_rsp%0d", k),
            64'({b_ready[k], b_resp[k], b_rdata[k]}), 64'(eb));
      check($sformatf("busy_tmo%0d", k), 64'({o_busy[k], o_tmo[k]}),
            64'({owner[k] != 0, ab}));
      if (ab) aborts_seen++;
      if (k == 1 && owner[k] != 0 && s_ready && age[k] > 20) long_done++;
   endtask

   task automatic step(input int k);
      bit ar, br;
      ar = a_trans != 0;
      br = b_trans != 0;
      if (owner[k] == 0) begin
         if (ar && (!br || prio[k] == 0)) begin
            owner[k] = 1; prio[k] = 1; age[k] = 1;
         end else if (br) begin
            if (ar) b_wins++;
            owner[k] = 2; prio[k] = 0; age[k] = 1;
         end
      end else if (s_ready || is_abort(k)) begin
         owner[k] = 0;
      end else begin
         age[k]++;
      end
   endtask

   function automatic logic [1:0] rand_trans();
      return ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
   endfunction

   initial begin
      rst = 1'b1;
      a_trans = '0; b_trans = '0; a_addr = '0; b_addr = '0;
      a_wdata = '0; b_wdata = '0; a_write = 1'b0; b_write = 1'b0;
      s_ready = 1'b0; s_resp = 1'b0; s_rdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      a_trans = 2'b10; b_trans = 2'b01; s_ready = 1'b1;
      s_resp = 1'b1; s_rdata = 32'hFFFF_FFFF;
      #1;
      compare(0);
      compare(1);
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         rst = (i > 20) && ($urandom_range(0, 299) == 0);
         a_trans = rand_trans();
         b_trans = rand_trans();
         a_addr  = $urandom; b_addr  = $urandom;
         a_wdata = $urandom; b_wdata = $urandom;
         a_write = 1'($urandom); b_write = 1'($urandom);
         s_resp  = 1'($urandom);
         s_rdata = $urandom;
         if (i < 3000) s_ready = 1'($urandom);
         else s_ready = ($urandom_range(0, 39) == 0);
         if (rst) model_reset();
         #1;
         compare(0);
         compare(1);
         @(posedge clk);
         if (!rst) begin
            step(0);
            step(1);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      check("abort_seen", 64'(aborts_seen > 0), 64'd1);
      check("long_stall_done", 64'(long_done > 0), 64'd1);
      check("b_won_tie", 64'(b_wins > 0), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
